// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard unit, forwarding unit and E-stage operand muxes.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } init_state_e;

    // E-stage operand select: the younger M-stage result wins over W.
    function automatic logic [1:0] fwd_sel(
        input logic       reg_write_m,
        input logic [4:0] write_reg_m,
        input logic       reg_write_w,
        input logic [4:0] write_reg_w,
        input logic [4:0] src
    );
        if (reg_write_m && (write_reg_m != REG_ZERO) && (write_reg_m == src))
            return FWD_M;
        else if (reg_write_w && (write_reg_w != REG_ZERO) && (write_reg_w == src))
            return FWD_W;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_busy_ctr.sv
// Tracks an in-flight multi-cycle MDU operation: load on start, count down to idle.
module mdu_busy_ctr #(
    parameter int MDU_LATENCY = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);
    localparam int CW = $clog2(MDU_LATENCY + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A start while busy simply reloads; legal flow never does this.
    always_comb begin
        cnt_d = cnt_q;
        if (start)
            cnt_d = CW'(MDU_LATENCY);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection, stall/flush and forwarding control for the 5-stage MIPS pipeline,
// including post-reset pipeline clearing and MDU busy stalls.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int INIT_FLUSH_CYCLES = 2,
    parameter int MDU_LATENCY       = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MemtoRegM,
    input  logic       BranchD,
    input  logic       PCSrcD,
    input  logic       JumpD,
    input  logic       MduOpD,
    input  logic       MduStartE,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MduBusy
);
    localparam int INIT_W = $clog2(INIT_FLUSH_CYCLES + 1);

    init_state_e     state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;

    logic initstall, lwstall, branchstall, mdustall, stall;
    logic hz_e, hz_m;

    // The D/E register has no reset, so bubbles are forced until the pipe is clean.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q - INIT_W'(1);
            if (init_cnt_q == INIT_W'(1))
                state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= INIT_W'(INIT_FLUSH_CYCLES);
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    assign initstall = (state_q == ST_INIT);

    mdu_busy_ctr #(
        .MDU_LATENCY (MDU_LATENCY)
    ) u_mdu_busy_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .start (MduStartE & ~initstall),
        .busy  (MduBusy)
    );

    // lwstall keeps $0 matches: an extra bubble is cheaper than the compare.
    assign lwstall  = MemtoRegE & ((RtE == RsD) | (RtE == RtD));
    assign mdustall = MduOpD & (MduBusy | MduStartE);

    assign hz_e = RegWriteE & (WriteRegE != REG_ZERO) & ((WriteRegE == RsD) | (WriteRegE == RtD));
    assign hz_m = MemtoRegM & (WriteRegM != REG_ZERO) & ((WriteRegM == RsD) | (WriteRegM == RtD));
    assign branchstall = BranchD & (hz_e | hz_m);

    assign stall  = initstall | lwstall | branchstall | mdustall;
    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;
    assign FlushD = (PCSrcD | JumpD) & ~stall;

    assign ForwardAD = RegWriteM & (WriteRegM != REG_ZERO) & (WriteRegM == RsD);
    assign ForwardBD = RegWriteM & (WriteRegM != REG_ZERO) & (WriteRegM == RtD);
    assign ForwardAE = fwd_sel(RegWriteM, WriteRegM, RegWriteW, WriteRegW, RsE);
    assign ForwardBE = fwd_sel(RegWriteM, WriteRegM, RegWriteW, WriteRegW, RtE);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       BranchD, PCSrcD, JumpD, MduOpD, MduStartE;
    logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MduBusy;
    logic [1:0] ForwardAE, ForwardBE;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.INIT_FLUSH_CYCLES(2), .MDU_LATENCY(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .PCSrcD(PCSrcD), .JumpD(JumpD),
        .MduOpD(MduOpD), .MduStartE(MduStartE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MduBusy(MduBusy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0;
        WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemtoRegM = 0;
        BranchD = 0; PCSrcD = 0; JumpD = 0; MduOpD = 0; MduStartE = 0;
    endtask

    // Release reset mid-cycle and check the stall holds for exactly two edges.
    task automatic test_init_release(input string tag);
        logic [2:0] got;
        rst_n = 1'b1;
        #1;
        for (int e = 0; e <= 2; e++) begin
            got = {StallF, StallD, FlushE};
            n_vec++;
            if (got !== ((e < 2) ? 3'b111 : 3'b000)) begin
                n_err++;
                $display("FAIL %s_edge%0d stall/flush=%b expected %b", tag, e, got, (e < 2) ? 3'b111 : 3'b000);
            end
            if (e < 2) tick();
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        PCSrcD = 1'b1;
        MduStartE = 1'b1;
        RegWriteM = 1'b1; WriteRegM = 5'd0; RsE = 5'd0;
        tick(); tick();
        n_vec++;
        if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
            n_err++;
            $display("FAIL reset_ctl got=%b expected 1110", {StallF, StallD, FlushE, FlushD});
        end
        n_vec++;
        if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD, MduBusy} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_fwd got=%b expected 0000000", {ForwardAE, ForwardBE, ForwardAD, ForwardBD, MduBusy});
        end
        // MduStartE stays high through INIT and must be ignored.
        test_init_release("init");
        MduStartE = 1'b0;
        PCSrcD = 1'b0;
        #1;
        n_vec++;
        if (MduBusy !== 1'b0) begin
            n_err++;
            $display("FAIL init_mdu_ignored MduBusy=%b expected 0", MduBusy);
        end
        tick();
    endtask

    task automatic test_lwstall();
        idle();
        MemtoRegE = 1'b1; RtE = 5'd8; RsD = 5'd8; RtD = 5'd2; PCSrcD = 1'b1;
        #1;
        n_vec++;
        if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
            n_err++;
            $display("FAIL lw_rs got=%b expected 1110", {StallF, StallD, FlushE, FlushD});
        end
        tick();
        idle();
        RegWriteM = 1'b1; WriteRegM = 5'd8; RsE = 5'd8; RsD = 5'd8;
        #1;
        n_vec++;
        if ({StallF, ForwardAE} !== 3'b010) begin
            n_err++;
            $display("FAIL lw_fwd stall,fae=%b expected 0_10", {StallF, ForwardAE});
        end
        idle();
        MemtoRegE = 1'b1; RtE = 5'd9; RsD = 5'd1; RtD = 5'd9;
        #1;
        n_vec++;
        if (StallD !== 1'b1) begin
            n_err++;
            $display("FAIL lw_rt StallD=%b expected 1", StallD);
        end
        RtE = 5'd0; RsD = 5'd0; RtD = 5'd3;
        #1;
        n_vec++;
        if (StallD !== 1'b1) begin
            n_err++;
            $display("FAIL lw_zero StallD=%b expected 1", StallD);
        end
        RsD = 5'd4;
        #1;
        n_vec++;
        if (StallD !== 1'b0) begin
            n_err++;
            $display("FAIL lw_nomatch StallD=%b expected 0", StallD);
        end
        tick();
    endtask

    task automatic test_forward();
        // {rwm, wrm, rww, wrw, rs, rt, fae, fbe, fad, fbd}
        logic [33:0] vec [6];
        logic [5:0] got;
        vec[0] = {1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd1, 2'b10, 2'b00, 1'b1, 1'b0};
        vec[1] = {1'b0, 5'd5, 1'b1, 5'd5, 5'd5, 5'd5, 2'b01, 2'b01, 1'b0, 1'b0};
        vec[2] = {1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0};
        vec[3] = {1'b1, 5'd7, 1'b1, 5'd6, 5'd6, 5'd7, 2'b01, 2'b10, 1'b0, 1'b1};
        vec[4] = {1'b1, 5'd31, 1'b0, 5'd31, 5'd31, 5'd31, 2'b10, 2'b10, 1'b1, 1'b1};
        vec[5] = {1'b0, 5'd3, 1'b0, 5'd3, 5'd3, 5'd3, 2'b00, 2'b00, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            idle();
            {RegWriteM, WriteRegM, RegWriteW, WriteRegW, RsE, RtE} = vec[i][33:6];
            RsD = RsE; RtD = RtE;
            #1;
            got = {ForwardAE, ForwardBE, ForwardAD, ForwardBD};
            n_vec++;
            if (got !== vec[i][5:0]) begin
                n_err++;
                $display("FAIL fwd_vec%0d got=%b expected %b", i, got, vec[i][5:0]);
            end
        end
        tick();
    endtask

    task automatic test_branch();
        idle();
        BranchD = 1'b1; RsD = 5'd3; RegWriteE = 1'b1; WriteRegE = 5'd3; PCSrcD = 1'b1;
        #1;
        n_vec++;
        if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
            n_err++;
            $display("FAIL br_ex got=%b expected 1110", {StallF, StallD, FlushE, FlushD});
        end
        tick();
        RegWriteE = 1'b0; WriteRegE = 5'd0;
        #1;
        n_vec++;
        if ({StallD, FlushD} !== 2'b01) begin
            n_err++;
            $display("FAIL br_taken stalld,flushd=%b expected 01", {StallD, FlushD});
        end
        PCSrcD = 1'b0; MemtoRegM = 1'b1; WriteRegM = 5'd4; RtD = 5'd4;
        #1;
        n_vec++;
        if ({StallD, FlushD} !== 2'b10) begin
            n_err++;
            $display("FAIL br_load_m stalld,flushd=%b expected 10", {StallD, FlushD});
        end
        idle();
        BranchD = 1'b1; RegWriteE = 1'b1; MemtoRegM = 1'b1;
        #1;
        n_vec++;
        if (StallD !== 1'b0) begin
            n_err++;
            $display("FAIL br_zero StallD=%b expected 0", StallD);
        end
        idle();
        RsD = 5'd3; RegWriteE = 1'b1; WriteRegE = 5'd3; JumpD = 1'b1;
        #1;
        n_vec++;
        if ({StallD, FlushD} !== 2'b01) begin
            n_err++;
            $display("FAIL jump_nobr stalld,flushd=%b expected 01", {StallD, FlushD});
        end
        tick();
    endtask

    task automatic start_mdu();
        idle();
        MduStartE = 1'b1; MduOpD = 1'b1;
        #1;
        n_vec++;
        if ({StallD, MduBusy} !== 2'b10) begin
            n_err++;
            $display("FAIL mdu_pulse stalld,busy=%b expected 10", {StallD, MduBusy});
        end
        tick();
        MduStartE = 1'b0;
        #1;
    endtask

    task automatic test_mdu();
        start_mdu();
        for (int k = 1; k <= 32; k++) begin
            n_vec++;
            if ({StallD, MduBusy} !== 2'b11) begin
                n_err++;
                $display("FAIL mdu_busy_c%0d stalld,busy=%b expected 11", k, {StallD, MduBusy});
            end
            if (k == 5) begin
                MduOpD = 1'b0;
                #1;
                n_vec++;
                if (StallD !== 1'b0) begin
                    n_err++;
                    $display("FAIL mdu_nodep StallD=%b expected 0", StallD);
                end
                MduOpD = 1'b1;
            end
            tick();
        end
        n_vec++;
        if ({StallD, MduBusy} !== 2'b00) begin
            n_err++;
            $display("FAIL mdu_done stalld,busy=%b expected 00", {StallD, MduBusy});
        end
        tick();
    endtask

    task automatic test_reset_mid_mdu();
        start_mdu();
        for (int k = 1; k < 10; k++) tick();
        n_vec++;
        if (MduBusy !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_busy MduBusy=%b expected 1", MduBusy);
        end
        MduOpD = 1'b0;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({MduBusy, StallF} !== 2'b01) begin
            n_err++;
            $display("FAIL rmid_clear busy,stallf=%b expected 01", {MduBusy, StallF});
        end
        tick();
        test_init_release("rmid_init");
        n_vec++;
        if (MduBusy !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_after MduBusy=%b expected 0", MduBusy);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_lwstall();
        test_forward();
        test_branch();
        test_mdu();
        test_reset_mid_mdu();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and pipeline-control unit for the 5-stage MIPS pipeline. It produces the StallF/StallD enables, the FlushD and FlushE bubble controls, and the forwarding selects consumed by the D/E, E/M and M/W stage registers and the E/D-stage muxes.
The D/E stage register has no reset and only a flush input. This block therefore owns the post-reset pipeline clearing and inserts all E-stage bubbles. It also holds a multi-cycle MDU busy tracker that stalls dependent HI/LO and MDU instructions in D.

Parameters:
INIT_FLUSH_CYCLES, 2, cycles after reset release during which FlushE/StallF/StallD are held (>=1)
MDU_LATENCY, 32, cycles the MDU is busy after MduStartE (>=1)

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
RsD, RtD  in  5 each  source registers of the D-stage instruction
RsE, RtE  in  5 each  source registers of the E-stage instruction
WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage
RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enable per stage
MemtoRegE, MemtoRegM  in  1 each  load in E / load in M
BranchD  in  1  beq/bne in D
PCSrcD  in  1  branch taken (resolved in D)
JumpD  in  1  j/jal/jr in D
MduOpD  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
MduStartE  in  1  mult/div is in E this cycle (one-cycle pulse)
StallF, StallD  out  1 each  hold PC / hold F/D register
FlushD  out  1  clear F/D register
FlushE  out  1  load bubble into D/E register
ForwardAD, ForwardBD  out  1 each  D-stage comparator operand from ALUOutM
ForwardAE, ForwardBE  out  2 each  E-stage ALU operand select: 00 regfile, 01 ResultW, 10 ALUOutM
MduBusy  out  1  MDU operation in flight

Behaviour:
- Reset (rst_n=0, asynchronous): InitCnt<=INIT_FLUSH_CYCLES and MduCnt<=0.
- Outputs during reset: StallF=StallD=FlushE=1, FlushD=0, all forwards 0, MduBusy=0.
- Init state machine: states INIT and RUN.
  - INIT lasts while InitCnt!=0; InitCnt decrements each clock. INIT->RUN when InitCnt reaches 0.
  - In INIT, initstall=1. MduStartE is ignored and MduCnt stays 0.
  - With the default of 2, FlushE stays high for exactly 2 rising edges after rst_n rises.
- MDU counter:
  - On an edge with MduStartE=1 in RUN, load MduCnt=MDU_LATENCY.
  - Otherwise, if MduCnt!=0, decrement by 1.
  - MduBusy = (MduCnt!=0). Width is clog2(MDU_LATENCY+1).
  - MduStartE while already busy reloads the counter (defensive; it cannot occur in legal flow).
- mdustall = MduOpD & (MduBusy | MduStartE). MduStartE is included so the op directly behind a mult/div stalls on the very next cycle.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- branchstall is BranchD AND either of the following:
  - RegWriteE & WriteRegE!=0 & (WriteRegE==RsD | WriteRegE==RtD)
  - MemtoRegM & WriteRegM!=0 & (WriteRegM==RsD | WriteRegM==RtD)
- stall = initstall | lwstall | branchstall | mdustall.
- Stall and flush outputs:
  - StallF = StallD = FlushE = stall.
  - FlushD = (PCSrcD | JumpD) & ~stall. A stalled branch is never flushed.
- ForwardAE:
  - 10 if RegWriteM & WriteRegM!=0 & WriteRegM==RsE.
  - else 01 if RegWriteW & WriteRegW!=0 & WriteRegW==RsE.
  - else 00.
  - M takes priority over W. ForwardBE is the same with RtE.
- ForwardAD = RegWriteM & WriteRegM!=0 & WriteRegM==RsD. ForwardBD is the same with RtD.
- Register $0 never forwards or creates a branch hazard. lwstall deliberately does not exclude $0 (harmless extra bubble).
- All stall, flush and forward outputs are combinational from inputs and state. Latency is 0 cycles; there is no registered output path.
- Reset asserted mid-MDU-operation: MduCnt is cleared immediately and INIT is re-entered.

Decomposition:
- Shared package: forward-select encodings FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10, and REG_ZERO=5'd0. The forwarding unit and the E-stage muxes import these.
- One natural sub-module, mdu_busy_ctr: load, decrement and busy flag; parameter MDU_LATENCY.

Test Plan:
- Release rst_n with all inputs 0 -> FlushE=StallF=StallD=1 for exactly 2 posedges, then 0; during reset FlushD=0.
- lw $8 in E (MemtoRegE=1, RtE=8) with RsD=8 -> StallF=StallD=FlushE=1 for 1 cycle. Next cycle, WriteRegM=8, RegWriteM=1, RsE=8 -> ForwardAE=10.
- RegWriteM=1, WriteRegM=5 and RegWriteW=1, WriteRegW=5, RsE=5 -> ForwardAE=10. WriteRegM=0 with RsE=0 -> ForwardAE=00.
- BranchD=1, RsD=3, RegWriteE=1, WriteRegE=3 -> stall 1 cycle. Then PCSrcD=1 with no hazard -> FlushD=1, StallD=0.
- MduStartE pulse with MduOpD=1 the same and following cycles -> stall held through the pulse cycle plus 32 cycles; MduBusy drops after 32 edges.
- rst_n pulsed low at cycle 10 of an MDU op -> MduBusy=0 immediately; 2-cycle init flush repeats.
